// File: rtl/renode_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package : renode_axi_pkg
// Purpose : Shared AXI4 types for the Renode AXI subordinate SRAM: response
//           codes, burst types, beat size and the write/read FSM state
//           encodings, plus a helper that merges per-beat responses.
// Ports   : none (package)
// Config  : RENODE_AXI_SUBORDINATE_EXCLUSIVE_EN is consumed by the top module.
// Revision: 1.0 - initial release
// ============================================================================
package renode_axi_pkg;

   typedef logic [2:0] burst_size_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } response_e;

   typedef enum logic [1:0] {
      Fixed    = 2'b00,
      Incr     = 2'b01,
      Wrap     = 2'b10,
      Reserved = 2'b11
   } burst_type_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } write_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_FETCH = 2'd1,
      R_DATA  = 2'd2
   } read_state_e;

   // Encodings are ordered by severity (SLVERR > EXOKAY > OKAY), so the
   // worst of two beat responses is simply the larger code.
   function automatic response_e worst_resp(input response_e a, input response_e b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/renode_axi_subordinate_sram_mem.sv
`default_nettype none
// ============================================================================
// Module  : renode_axi_subordinate_sram_mem
// Purpose : Two-port SRAM array. One byte-enabled synchronous write port and
//           one registered synchronous read port. The array has no reset.
//           A read and write of the same word in one cycle returns old data.
// Ports   : i_clk              clock
//           i_we/i_waddr/i_wstrb/i_wdata   write port (byte enables)
//           i_re/i_raddr       read request, o_rdata valid the next cycle
//           o_rdata            registered read data (held while i_re low)
// Revision: 1.0 - initial release
// ============================================================================
module renode_axi_subordinate_sram_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_we,
   input  logic [ADDR_WIDTH-1:0]   i_waddr,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic                    i_re,
   input  logic [ADDR_WIDTH-1:0]   i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int c_STRB_WIDTH = DATA_WIDTH / 8;
   localparam int c_DEPTH      = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < c_STRB_WIDTH; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/renode_axi_subordinate_sram.sv
`default_nettype none
// ============================================================================
// Module  : renode_axi_subordinate_sram
// Purpose : AXI4 subordinate backed by a byte-writable on-chip SRAM. Read and
//           write channels run independently, one outstanding transaction
//           each, single-beat or burst (FIXED/INCR; WRAP/reserved -> SLVERR).
// Ports   : i_aclk, i_areset_n (async active-low)
//           AW: i_awid i_awaddr i_awlen i_awsize i_awburst i_awlock i_awprot
//               i_awvalid / o_awready
//           W : i_wdata i_wstrb i_wlast i_wvalid / o_wready
//           B : o_bid o_bresp o_bvalid / i_bready
//           AR: i_arid i_araddr i_arlen i_arsize i_arburst i_arlock i_arprot
//               i_arvalid / o_arready
//           R : o_rid o_rdata o_rresp o_rlast o_rvalid / i_rready
// Config  : `RENODE_AXI_SUBORDINATE_EXCLUSIVE_EN enables a single-entry
//           exclusive-access monitor; otherwise lock signals are ignored.
// Revision: 1.0 - initial release
// ============================================================================
module renode_axi_subordinate_sram
   import renode_axi_pkg::*;
#(
   parameter int                     ADDRESS_WIDTH        = 20,
   parameter int                     DATA_WIDTH           = 32,
   parameter int                     TRANSACTION_ID_WIDTH = 8,
   parameter int                     MEM_ADDR_WIDTH       = 8,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS       = '0
) (
   input  logic                            i_aclk,
   input  logic                            i_areset_n,
   // AW
   input  logic [TRANSACTION_ID_WIDTH-1:0] i_awid,
   input  logic [ADDRESS_WIDTH-1:0]        i_awaddr,
   input  logic [7:0]                      i_awlen,
   input  logic [2:0]                      i_awsize,
   input  logic [1:0]                      i_awburst,
   input  logic                            i_awlock,
   input  logic [2:0]                      i_awprot,
   input  logic                            i_awvalid,
   output logic                            o_awready,
   // W
   input  logic [DATA_WIDTH-1:0]           i_wdata,
   input  logic [DATA_WIDTH/8-1:0]         i_wstrb,
   input  logic                            i_wlast,
   input  logic                            i_wvalid,
   output logic                            o_wready,
   // B
   output logic [TRANSACTION_ID_WIDTH-1:0] o_bid,
   output logic [1:0]                      o_bresp,
   output logic                            o_bvalid,
   input  logic                            i_bready,
   // AR
   input  logic [TRANSACTION_ID_WIDTH-1:0] i_arid,
   input  logic [ADDRESS_WIDTH-1:0]        i_araddr,
   input  logic [7:0]                      i_arlen,
   input  logic [2:0]                      i_arsize,
   input  logic [1:0]                      i_arburst,
   input  logic                            i_arlock,
   input  logic [2:0]                      i_arprot,
   input  logic                            i_arvalid,
   output logic                            o_arready,
   // R
   output logic [TRANSACTION_ID_WIDTH-1:0] o_rid,
   output logic [DATA_WIDTH-1:0]           o_rdata,
   output logic [1:0]                      o_rresp,
   output logic                            o_rlast,
   output logic                            o_rvalid,
   input  logic                            i_rready
);

   localparam int                       c_STRB_WIDTH = DATA_WIDTH / 8;
   localparam int                       c_LSB        = $clog2(c_STRB_WIDTH);
   localparam burst_size_t              c_MAX_SIZE   = burst_size_t'(c_LSB);
   localparam logic [ADDRESS_WIDTH:0]   c_MEM_SIZE   =
      (ADDRESS_WIDTH+1)'(c_STRB_WIDTH) << MEM_ADDR_WIDTH;

   // Offset is computed one bit wider so addresses below the base borrow into
   // the top bit and land outside the window.
   function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
      logic [ADDRESS_WIDTH:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDRESS};
      return off < c_MEM_SIZE;
   endfunction

   function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a,
                                                          input burst_size_t s,
                                                          input burst_type_e b);
      if (b == Incr) return a + (ADDRESS_WIDTH'(1) << s);
      return a;
   endfunction

   // Ready outputs stay low until the first clock edge after reset release.
   logic r_ready_en;

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) r_ready_en <= 1'b0;
      else             r_ready_en <= 1'b1;
   end

   // ------------------------------------------------------------------ write
   write_state_e                    r_wstate, w_wstate_nxt;
   logic [TRANSACTION_ID_WIDTH-1:0] r_awid;
   logic [ADDRESS_WIDTH-1:0]        r_waddr;
   logic [7:0]                      r_awlen;
   logic [7:0]                      r_wbeat;
   burst_size_t                     r_awsize;
   burst_type_e                     r_awburst;
   response_e                       r_bresp;

   logic       w_aw_hs, w_w_hs, w_wlast_exp, w_wdone, w_wbeat_err;
   logic       w_wexcl, w_wexcl_ok, w_mem_we;
   response_e  w_wbeat_resp;
   logic [MEM_ADDR_WIDTH-1:0] w_wword;

   assign w_aw_hs     = o_awready & i_awvalid;
   assign w_w_hs      = o_wready & i_wvalid;
   assign w_wlast_exp = (r_wbeat == r_awlen);
   // Burst closes on wlast or, if wlast never comes, after awlen+1 beats.
   assign w_wdone     = i_wlast | w_wlast_exp;
   assign w_wword     = r_waddr[c_LSB +: MEM_ADDR_WIDTH];
   assign w_wbeat_err = !addr_ok(r_waddr) || (r_awsize > c_MAX_SIZE) ||
                        (r_awburst == Wrap) || (r_awburst == Reserved) ||
                        (i_wlast != w_wlast_exp);
   assign w_wbeat_resp = w_wbeat_err ? SLVERR :
                         (w_wexcl && w_wexcl_ok) ? EXOKAY : OKAY;
   assign w_mem_we    = w_w_hs && !w_wbeat_err && (!w_wexcl || w_wexcl_ok);

   always_comb begin
      w_wstate_nxt = r_wstate;
      o_awready    = 1'b0;
      o_wready     = 1'b0;
      o_bvalid     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            o_awready = r_ready_en;
            if (r_ready_en && i_awvalid) w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            o_wready = 1'b1;
            if (i_wvalid && w_wdone) w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            o_bvalid = 1'b1;
            if (i_bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_wstate  <= W_IDLE;
         r_awid    <= '0;
         r_waddr   <= '0;
         r_awlen   <= '0;
         r_wbeat   <= '0;
         r_awsize  <= '0;
         r_awburst <= Fixed;
         r_bresp   <= OKAY;
      end else begin
         r_wstate <= w_wstate_nxt;
         if (w_aw_hs) begin
            r_awid    <= i_awid;
            r_waddr   <= i_awaddr;
            r_awlen   <= i_awlen;
            r_wbeat   <= '0;
            r_awsize  <= i_awsize;
            r_awburst <= burst_type_e'(i_awburst);
            r_bresp   <= OKAY;
         end
         if (w_w_hs) begin
            r_wbeat <= r_wbeat + 8'd1;
            r_waddr <= next_addr(r_waddr, r_awsize, r_awburst);
            r_bresp <= worst_resp(r_bresp, w_wbeat_resp);
         end
      end
   end

   assign o_bid   = r_awid;
   assign o_bresp = r_bresp;

   // ------------------------------------------------------------------- read
   read_state_e                     r_rstate, w_rstate_nxt;
   logic [TRANSACTION_ID_WIDTH-1:0] r_arid;
   logic [ADDRESS_WIDTH-1:0]        r_raddr;
   logic [7:0]                      r_arlen;
   logic [7:0]                      r_rbeat;
   burst_size_t                     r_arsize;
   burst_type_e                     r_arburst;
   logic                            r_rerr;
   logic                            r_rlast;
   response_e                       r_rresp;

   logic                      w_ar_hs, w_rbeat_err, w_rexcl;
   logic [DATA_WIDTH-1:0]     w_mem_rdata;

   assign w_ar_hs     = o_arready & i_arvalid;
   assign w_rbeat_err = !addr_ok(r_raddr) || (r_arsize > c_MAX_SIZE) ||
                        (r_arburst == Wrap) || (r_arburst == Reserved);

   always_comb begin
      w_rstate_nxt = r_rstate;
      o_arready    = 1'b0;
      o_rvalid     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            o_arready = r_ready_en;
            if (r_ready_en && i_arvalid) w_rstate_nxt = R_FETCH;
         end
         R_FETCH: w_rstate_nxt = R_DATA;
         R_DATA: begin
            o_rvalid = 1'b1;
            if (i_rready) w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_rstate  <= R_IDLE;
         r_arid    <= '0;
         r_raddr   <= '0;
         r_arlen   <= '0;
         r_rbeat   <= '0;
         r_arsize  <= '0;
         r_arburst <= Fixed;
         r_rerr    <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= OKAY;
      end else begin
         r_rstate <= w_rstate_nxt;
         if (w_ar_hs) begin
            r_arid    <= i_arid;
            r_raddr   <= i_araddr;
            r_arlen   <= i_arlen;
            r_rbeat   <= '0;
            r_arsize  <= i_arsize;
            r_arburst <= burst_type_e'(i_arburst);
         end
         // Beat attributes are latched alongside the SRAM read so they stay
         // stable for the whole R_DATA phase.
         if (r_rstate == R_FETCH) begin
            r_rerr  <= w_rbeat_err;
            r_rlast <= (r_rbeat == r_arlen);
            r_rresp <= w_rbeat_err ? SLVERR : (w_rexcl ? EXOKAY : OKAY);
         end
         if ((r_rstate == R_DATA) && i_rready) begin
            r_rbeat <= r_rbeat + 8'd1;
            r_raddr <= next_addr(r_raddr, r_arsize, r_arburst);
         end
      end
   end

   assign o_rid   = r_arid;
   assign o_rresp = r_rresp;
   assign o_rlast = r_rlast;
   // SRAM read register is not reset; gating keeps rdata at 0 outside beats
   // and on error beats.
   assign o_rdata = ((r_rstate == R_DATA) && !r_rerr) ? w_mem_rdata : '0;

   // ------------------------------------------------------- exclusive monitor
`ifdef RENODE_AXI_SUBORDINATE_EXCLUSIVE_EN
   logic                            r_excl_valid;
   logic [TRANSACTION_ID_WIDTH-1:0] r_excl_id;
   logic [MEM_ADDR_WIDTH-1:0]       r_excl_word;
   logic                            r_awlock;
   logic                            r_excl_pass;
   logic                            r_arlock;

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_excl_valid <= 1'b0;
         r_excl_id    <= '0;
         r_excl_word  <= '0;
         r_awlock     <= 1'b0;
         r_excl_pass  <= 1'b0;
         r_arlock     <= 1'b0;
      end else begin
         // Match is decided once per burst, at address acceptance.
         if (w_aw_hs) begin
            r_awlock    <= i_awlock;
            r_excl_pass <= i_awlock && r_excl_valid && (i_awid == r_excl_id) &&
                           (i_awaddr[c_LSB +: MEM_ADDR_WIDTH] == r_excl_word);
         end
         if (w_ar_hs) r_arlock <= i_arlock;
         // Any performed write to the reserved word drops the reservation;
         // a new exclusive read in the same cycle takes priority.
         if (w_mem_we && (w_wword == r_excl_word)) r_excl_valid <= 1'b0;
         if (w_ar_hs && i_arlock) begin
            r_excl_valid <= 1'b1;
            r_excl_id    <= i_arid;
            r_excl_word  <= i_araddr[c_LSB +: MEM_ADDR_WIDTH];
         end
      end
   end

   assign w_wexcl    = r_awlock;
   assign w_wexcl_ok = r_excl_pass;
   assign w_rexcl    = r_arlock;
`else
   assign w_wexcl    = 1'b0;
   assign w_wexcl_ok = 1'b0;
   assign w_rexcl    = 1'b0;
`endif

   // Protection and (in the default build) lock inputs carry no function.
   logic w_unused;
   assign w_unused = ^{i_awprot, i_arprot, i_awlock, i_arlock};

   // ------------------------------------------------------------------- SRAM
   renode_axi_subordinate_sram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_mem (
      .i_clk   (i_aclk),
      .i_we    (w_mem_we),
      .i_waddr (w_wword),
      .i_wstrb (i_wstrb),
      .i_wdata (i_wdata),
      .i_re    (r_rstate == R_FETCH),
      .i_raddr (r_raddr[c_LSB +: MEM_ADDR_WIDTH]),
      .o_rdata (w_mem_rdata)
   );

endmodule
`default_nettype wire
